// File: rtl/cache_mem_arbiter.sv
// Shares one memory refill/write-back port between icache (read) and dcache (read + write-back).
// Optional `ARB_RR_EN` swaps fixed dcache-priority read arbitration for round-robin.
module cache_mem_arbiter (
    input  logic         clk,
    input  logic         resetn,
    // icache read
    input  logic         i_rd_req,
    input  logic [2:0]   i_rd_type,
    input  logic [31:0]  i_rd_addr,
    output logic         i_rd_rdy,
    output logic         i_ret_valid,
    output logic         i_ret_last,
    // dcache read
    input  logic         d_rd_req,
    input  logic [2:0]   d_rd_type,
    input  logic [31:0]  d_rd_addr,
    output logic         d_rd_rdy,
    output logic         d_ret_valid,
    output logic         d_ret_last,
    output logic [31:0]  ret_data,
    // dcache write-back
    input  logic         d_wr_req,
    input  logic [2:0]   d_wr_type,
    input  logic [31:0]  d_wr_addr,
    input  logic [3:0]   d_wr_wstrb,
    input  logic [127:0] d_wr_data,
    output logic         d_wr_rdy,
    // bridge read
    output logic         mem_rd_req,
    output logic [2:0]   mem_rd_type,
    output logic [31:0]  mem_rd_addr,
    input  logic         mem_rd_rdy,
    input  logic         mem_ret_valid,
    input  logic         mem_ret_last,
    input  logic [31:0]  mem_ret_data,
    // bridge write
    output logic         mem_wr_req,
    output logic [2:0]   mem_wr_type,
    output logic [31:0]  mem_wr_addr,
    output logic [3:0]   mem_wr_wstrb,
    output logic [127:0] mem_wr_data,
    input  logic         mem_wr_rdy,
    input  logic         mem_wr_done
);

    typedef enum logic [2:0] {
        R_IDLE = 3'b001,
        R_REQ  = 3'b010,
        R_RESP = 3'b100
    } rd_state_t;

    typedef enum logic [2:0] {
        W_IDLE = 3'b001,
        W_REQ  = 3'b010,
        W_WAIT = 3'b100
    } wr_state_t;

    rd_state_t      r_rd_state;
    wr_state_t      r_wr_state;

    logic [31:0]    r_rd_addr;
    logic [2:0]     r_rd_type;
    logic           r_owner;        // 0 = icache, 1 = dcache

    logic [31:0]    r_wr_addr;
    logic [2:0]     r_wr_type;
    logic [3:0]     r_wr_wstrb;
    logic [127:0]   r_wr_data;

    logic           w_rd_idle;
    logic           w_wr_idle;
    logic           w_wr_accept;
    logic           w_wr_pending;
    logic           w_i_hazard;
    logic           w_d_hazard;
    logic           w_i_elig;
    logic           w_d_elig;
    logic           w_grant_i;
    logic           w_grant_d;
    logic           w_in_resp;

    assign w_rd_idle    = (r_rd_state == R_IDLE);
    assign w_wr_idle    = (r_wr_state == W_IDLE);
    assign w_wr_accept  = w_wr_idle & d_wr_req;
    assign w_wr_pending = ~w_wr_idle;
    assign w_in_resp    = (r_rd_state == R_RESP);

    // A read of a line that is buffered or being accepted for write-back would fetch stale memory.
    assign w_i_hazard = (w_wr_pending & (i_rd_addr[31:4] == r_wr_addr[31:4])) |
                        (w_wr_accept  & (i_rd_addr[31:4] == d_wr_addr[31:4]));
    assign w_d_hazard = (w_wr_pending & (d_rd_addr[31:4] == r_wr_addr[31:4])) |
                        (w_wr_accept  & (d_rd_addr[31:4] == d_wr_addr[31:4]));

    assign w_i_elig = i_rd_req & ~w_i_hazard;
    assign w_d_elig = d_rd_req & ~w_d_hazard;

`ifdef ARB_RR_EN
    logic r_last_grant;             // 1 = dcache won most recently

    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (w_i_elig && w_d_elig) begin
            w_grant_d = ~r_last_grant;
            w_grant_i = r_last_grant;
        end else begin
            w_grant_i = w_i_elig;
            w_grant_d = w_d_elig;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_grant <= 1'b1;
        end else if (w_rd_idle && (w_grant_i || w_grant_d)) begin
            r_last_grant <= w_grant_d;
        end
    end
`else
    always_comb begin
        w_grant_d = w_d_elig;
        w_grant_i = w_i_elig & ~w_d_elig;
    end
`endif

    // Qualified with resetn so no handshake leaks out while reset is held.
    assign i_rd_rdy = resetn & w_rd_idle & w_grant_i;
    assign d_rd_rdy = resetn & w_rd_idle & w_grant_d;
    assign d_wr_rdy = w_wr_idle;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_state <= R_IDLE;
            r_rd_addr  <= 32'd0;
            r_rd_type  <= 3'd0;
            r_owner    <= 1'b0;
        end else begin
            unique case (r_rd_state)
                R_IDLE: begin
                    if (w_grant_d) begin
                        r_rd_addr  <= d_rd_addr;
                        r_rd_type  <= d_rd_type;
                        r_owner    <= 1'b1;
                        r_rd_state <= R_REQ;
                    end else if (w_grant_i) begin
                        r_rd_addr  <= i_rd_addr;
                        r_rd_type  <= i_rd_type;
                        r_owner    <= 1'b0;
                        r_rd_state <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (mem_rd_rdy) begin
                        r_rd_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (mem_ret_valid && mem_ret_last) begin
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_state <= W_IDLE;
            r_wr_addr  <= 32'd0;
            r_wr_type  <= 3'd0;
            r_wr_wstrb <= 4'd0;
            r_wr_data  <= 128'd0;
        end else begin
            unique case (r_wr_state)
                W_IDLE: begin
                    if (d_wr_req) begin
                        r_wr_addr  <= d_wr_addr;
                        r_wr_type  <= d_wr_type;
                        r_wr_wstrb <= d_wr_wstrb;
                        r_wr_data  <= d_wr_data;
                        r_wr_state <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (mem_wr_rdy) begin
                        r_wr_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (mem_wr_done) begin
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    assign mem_rd_req   = (r_rd_state == R_REQ);
    assign mem_rd_addr  = r_rd_addr;
    assign mem_rd_type  = r_rd_type;

    assign mem_wr_req   = (r_wr_state == W_REQ);
    assign mem_wr_addr  = r_wr_addr;
    assign mem_wr_type  = r_wr_type;
    assign mem_wr_wstrb = r_wr_wstrb;
    assign mem_wr_data  = r_wr_data;

    // Beats outside R_RESP are dropped; inside, they are steered by the latched owner.
    assign i_ret_valid  = w_in_resp & mem_ret_valid & ~r_owner;
    assign d_ret_valid  = w_in_resp & mem_ret_valid &  r_owner;
    assign i_ret_last   = w_in_resp & mem_ret_valid & mem_ret_last & ~r_owner;
    assign d_ret_last   = w_in_resp & mem_ret_valid & mem_ret_last &  r_owner;
    assign ret_data     = mem_ret_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reads, arbitration, write-back hazard, overlap, backpressure, reset.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         resetn;
    logic         i_rd_req, d_rd_req, d_wr_req;
    logic [2:0]   i_rd_type, d_rd_type, d_wr_type;
    logic [31:0]  i_rd_addr, d_rd_addr, d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;
    logic         i_rd_rdy, i_ret_valid, i_ret_last;
    logic         d_rd_rdy, d_ret_valid, d_ret_last, d_wr_rdy;
    logic [31:0]  ret_data;
    logic         mem_rd_req, mem_rd_rdy, mem_ret_valid, mem_ret_last;
    logic [2:0]   mem_rd_type, mem_wr_type;
    logic [31:0]  mem_rd_addr, mem_ret_data, mem_wr_addr;
    logic         mem_wr_req, mem_wr_rdy, mem_wr_done;
    logic [3:0]   mem_wr_wstrb;
    logic [127:0] mem_wr_data;

    int checks = 0;
    int errors = 0;
    logic first;

    localparam logic [127:0] WDATA_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] WDATA_B = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .ret_data(ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
        .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid),
        .mem_ret_last(mem_ret_last), .mem_ret_data(mem_ret_data),
        .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
        .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data),
        .mem_wr_rdy(mem_wr_rdy), .mem_wr_done(mem_wr_done)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %032h expected %032h", tag, obs, exp);
        end
    endtask

    // Cycle after a grant: drop the granted request, check the memory request, accept it.
    task automatic rd_req_phase(input logic [31:0] addr, input logic clr_i, input logic clr_d);
        @(negedge clk);
        if (clr_i) i_rd_req = 1'b0;
        if (clr_d) d_rd_req = 1'b0;
        mem_rd_rdy = 1'b1;
        #1;
        chk1("mem_rd_req_on", mem_rd_req, 1'b1);
        chk32("mem_rd_addr", mem_rd_addr, addr);
        chk1("i_rdy_busy", i_rd_rdy, 1'b0);
        chk1("d_rdy_busy", d_rd_rdy, 1'b0);
        $display("read request addr=%08h issued to memory", addr);
    endtask

    // Four return beats base..base+3, then one idle cycle (earliest re-grant point).
    task automatic rd_beats(input logic own, input logic [31:0] base);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_rd_rdy    = 1'b0;
            mem_wr_rdy    = 1'b0;
            mem_ret_valid = 1'b1;
            mem_ret_data  = base + 32'(k);
            mem_ret_last  = (k == 3);
            #1;
            chk1("i_ret_valid", i_ret_valid, ~own);
            chk1("d_ret_valid", d_ret_valid, own);
            chk1("ret_last", own ? d_ret_last : i_ret_last, (k == 3));
            chk32("ret_data", ret_data, base + 32'(k));
            chk1("rdy_in_resp", i_rd_rdy | d_rd_rdy, 1'b0);
        end
        @(negedge clk);
        mem_ret_valid = 1'b0;
        mem_ret_last  = 1'b0;
        mem_ret_data  = 32'd0;
        #1;
        $display("read owner=%0d returned beats %08h..%08h", own, base, base + 32'd3);
    endtask

    task automatic do_read(input logic own, input logic [31:0] addr, input logic [31:0] base,
                           input logic clr_i, input logic clr_d);
        rd_req_phase(addr, clr_i, clr_d);
        rd_beats(own, base);
    endtask

    initial begin
        resetn = 1'b0;
        i_rd_req = 0; i_rd_type = 3'd4; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 3'd4; d_rd_addr = 0;
        d_wr_req = 0; d_wr_type = 3'd4; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0;
        mem_rd_rdy = 0; mem_ret_valid = 0; mem_ret_last = 0; mem_ret_data = 0;
        mem_wr_rdy = 0; mem_wr_done = 0;
        repeat (3) @(negedge clk);
        #1;
        chk1("rst_d_wr_rdy", d_wr_rdy, 1'b1);
        chk1("rst_mem_rd_req", mem_rd_req, 1'b0);
        chk1("rst_mem_wr_req", mem_wr_req, 1'b0);
        chk32("rst_mem_rd_addr", mem_rd_addr, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk1("idle_i_rdy", i_rd_rdy, 1'b0);
        chk1("idle_d_ret", d_ret_valid, 1'b0);
        $display("reset released");

        // 1: single icache read
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_addr = 32'h1C000100;
        #1;
        chk1("t1_i_rdy", i_rd_rdy, 1'b1);
        chk1("t1_d_rdy", d_rd_rdy, 1'b0);
        do_read(1'b0, 32'h1C000100, 32'hA0, 1'b1, 1'b0);

        // 2: simultaneous requests, dcache wins (last winner was the icache)
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_addr = 32'h100;
        d_rd_req = 1'b1; d_rd_addr = 32'h200;
        #1;
        chk1("t2_d_rdy", d_rd_rdy, 1'b1);
        chk1("t2_i_rdy", i_rd_rdy, 1'b0);
        do_read(1'b1, 32'h200, 32'hB0, 1'b0, 1'b1);
        chk1("t2_i_regrant", i_rd_rdy, 1'b1);
        do_read(1'b0, 32'h100, 32'hC0, 1'b1, 1'b0);

        // 2b: after a lone dcache read, a simultaneous pair shows the arbitration policy
        @(negedge clk);
        d_rd_req = 1'b1; d_rd_addr = 32'h240;
        #1;
        chk1("t2b_d_rdy", d_rd_rdy, 1'b1);
        do_read(1'b1, 32'h240, 32'hD0, 1'b0, 1'b1);
`ifdef ARB_RR_EN
        first = 1'b0;
`else
        first = 1'b1;
`endif
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_addr = 32'h100;
        d_rd_req = 1'b1; d_rd_addr = 32'h200;
        #1;
        chk1("t2b_pair_d", d_rd_rdy, first);
        chk1("t2b_pair_i", i_rd_rdy, ~first);
        do_read(first, first ? 32'h200 : 32'h100, 32'hE0, ~first, first);
        chk1("t2b_second_d", d_rd_rdy, ~first);
        chk1("t2b_second_i", i_rd_rdy, first);
        do_read(~first, first ? 32'h100 : 32'h200, 32'hE8, first, ~first);

        // 3: write-back hazard
        @(negedge clk);
        d_wr_req = 1'b1; d_wr_addr = 32'h00800040; d_wr_wstrb = 4'hF; d_wr_data = WDATA_A;
        #1;
        chk1("t3_wr_rdy", d_wr_rdy, 1'b1);
        @(negedge clk);
        d_wr_req = 1'b0; d_wr_data = 128'd0; mem_wr_done = 1'b1;
        #1;
        chk1("t3_mem_wr_req", mem_wr_req, 1'b1);
        chk32("t3_mem_wr_addr", mem_wr_addr, 32'h00800040);
        chk128("t3_mem_wr_data", mem_wr_data, WDATA_A);
        chk1("t3_wr_rdy_busy", d_wr_rdy, 1'b0);
        @(negedge clk);
        mem_wr_done = 1'b0; mem_wr_rdy = 1'b1;
        #1;
        chk1("t3_stray_done", mem_wr_req, 1'b1);
        @(negedge clk);
        mem_wr_rdy = 1'b0;
        d_rd_req = 1'b1; d_rd_addr = 32'h00800048;
        i_rd_req = 1'b1; i_rd_addr = 32'h300;
        #1;
        chk1("t3_wr_wait", mem_wr_req, 1'b0);
        chk1("t3_d_blocked", d_rd_rdy, 1'b0);
        chk1("t3_i_granted", i_rd_rdy, 1'b1);
        $display("write-back line 00800040 waiting; icache read 300 granted");
        do_read(1'b0, 32'h300, 32'hF0, 1'b1, 1'b0);
        chk1("t3_d_still_blocked", d_rd_rdy, 1'b0);
        @(negedge clk);
        mem_wr_done = 1'b1;
        #1;
        chk1("t3_d_blocked_done", d_rd_rdy, 1'b0);
        @(negedge clk);
        mem_wr_done = 1'b0;
        #1;
        chk1("t3_d_after_done", d_rd_rdy, 1'b1);
        chk1("t3_wr_rdy_free", d_wr_rdy, 1'b1);
        do_read(1'b1, 32'h00800048, 32'h10, 1'b0, 1'b1);

        // 4: write and icache read accepted together; dcache read of the same-cycle write line blocked
        @(negedge clk);
        d_wr_req = 1'b1; d_wr_addr = 32'h00400000; d_wr_wstrb = 4'h5; d_wr_data = WDATA_B;
        i_rd_req = 1'b1; i_rd_addr = 32'h500;
        d_rd_req = 1'b1; d_rd_addr = 32'h00400004;
        #1;
        chk1("t4_wr_rdy", d_wr_rdy, 1'b1);
        chk1("t4_i_rdy", i_rd_rdy, 1'b1);
        chk1("t4_d_same_cycle_haz", d_rd_rdy, 1'b0);
        @(negedge clk);
        d_wr_req = 1'b0; d_wr_data = 128'd0; i_rd_req = 1'b0;
        mem_rd_rdy = 1'b1; mem_wr_rdy = 1'b1;
        #1;
        chk1("t4_mem_wr_req", mem_wr_req, 1'b1);
        chk1("t4_mem_rd_req", mem_rd_req, 1'b1);
        chk128("t4_mem_wr_data", mem_wr_data, WDATA_B);
        chk32("t4_mem_wr_wstrb", {28'd0, mem_wr_wstrb}, 32'h5);
        chk32("t4_mem_rd_addr", mem_rd_addr, 32'h500);
        $display("overlap: write 00400000 and read 500 both at memory");
        rd_beats(1'b0, 32'hA8);
        chk1("t4_d_blocked", d_rd_rdy, 1'b0);
        @(negedge clk);
        mem_wr_done = 1'b1;
        @(negedge clk);
        mem_wr_done = 1'b0;
        #1;
        chk1("t4_d_granted", d_rd_rdy, 1'b1);
        do_read(1'b1, 32'h00400004, 32'h20, 1'b0, 1'b1);

        // 5: read backpressure with a stray return beat
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_addr = 32'h600;
        #1;
        chk1("t5_i_rdy", i_rd_rdy, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_rd_req = 1'b0;
            d_rd_req = 1'b1; d_rd_addr = 32'h700;
            mem_ret_valid = (c == 2); mem_ret_last = (c == 2);
            #1;
            chk1("t5_rd_req_held", mem_rd_req, 1'b1);
            chk32("t5_rd_addr_held", mem_rd_addr, 32'h600);
            chk1("t5_d_no_rdy", d_rd_rdy, 1'b0);
            chk1("t5_no_ret", i_ret_valid | d_ret_valid, 1'b0);
        end
        mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
        do_read(1'b0, 32'h600, 32'h30, 1'b1, 1'b0);
        chk1("t5_d_granted", d_rd_rdy, 1'b1);
        do_read(1'b1, 32'h700, 32'h40, 1'b0, 1'b1);

        // 6: reset in the middle of a response
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_addr = 32'h800;
        #1;
        chk1("t6_i_rdy", i_rd_rdy, 1'b1);
        rd_req_phase(32'h800, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_rd_rdy = 1'b0;
            mem_ret_valid = 1'b1; mem_ret_data = 32'h50 + 32'(k);
            #1;
            chk1("t6_beat", i_ret_valid, 1'b1);
        end
        @(negedge clk);
        mem_ret_data = 32'd0;
        resetn = 1'b0;
        #1;
        chk1("t6_rst_i_ret", i_ret_valid, 1'b0);
        chk1("t6_rst_d_ret", d_ret_valid, 1'b0);
        chk1("t6_rst_rd_req", mem_rd_req, 1'b0);
        chk32("t6_rst_rd_addr", mem_rd_addr, 32'd0);
        chk1("t6_rst_wr_rdy", d_wr_rdy, 1'b1);
        chk1("t6_rst_i_rdy", i_rd_rdy, 1'b0);
        $display("reset asserted during response");
        @(negedge clk);
        resetn = 1'b1; mem_ret_valid = 1'b0;
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_addr = 32'h900;
        #1;
        chk1("t6_post_rst_rdy", i_rd_rdy, 1'b1);
        do_read(1'b0, 32'h900, 32'h60, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
